edge_det_multi: RTL

Parametrised multi-channel edge detector for asynchronous slave-side inputs (SCLK, CS_N, MOSI, external strobes). Each channel synchronises its input, optionally rejects glitches, produces registered one-cycle rising and falling pulses, and raises a mode-qualified sticky pending flag with an OR-reduced interrupt. It replaces single-purpose positive-edge and negative-edge detectors in the SPI slave front end.

---
 rtl/edge_det_pkg.sv | 25 ++
 rtl/edge_det_chan.sv | 70 +++++++
 rtl/edge_det_multi.sv | 43 ++++
 3 files changed

// File: rtl/edge_det_pkg.sv
// Shared constants and helpers for the multi-channel edge detector.
// Mode encoding selects which accepted transitions raise an event.
package edge_det_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Filter counter must hold 0..FILT_CYCLES-1; keep at least one bit.
    function automatic int cnt_width(input int filt_cycles);
        int w;
        w = $clog2(filt_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic rise_en(input logic [1:0] m);
        return (m == MODE_RISE) || (m == MODE_BOTH);
    endfunction

    function automatic logic fall_en(input logic [1:0] m);
        return (m == MODE_FALL) || (m == MODE_BOTH);
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, glitch filter, registered
// rise/fall pulses, mode-qualified event and sticky pending flag.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level,
    output logic       pe,
    output logic       ne,
    output logic       ev,
    output logic       pend
);

    localparam int              CW       = cnt_width(FILT_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic                   lvl_upd;
    logic                   pe_nxt;
    logic                   ne_nxt;
    logic                   ev_nxt;

    assign s = sync_p0[SYNC_STAGES-1];

    always_comb begin
        lvl_upd = (s != level) && (cnt == CNT_LAST);
        pe_nxt  = lvl_upd & s;
        ne_nxt  = lvl_upd & ~s;
        ev_nxt  = (rise_en(mode) & pe_nxt) | (fall_en(mode) & ne_nxt);
    end

    // Reset clears the synchroniser too, so a high input at release is
    // reported as a rising edge rather than silently adopted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            pe      <= 1'b0;
            ne      <= 1'b0;
            ev      <= 1'b0;
            pend    <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig};
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            pe   <= pe_nxt;
            ne   <= ne_nxt;
            ev   <= ev_nxt;
            // A pending set always beats a simultaneous clear.
            pend <= ev | (pend & ~clr);
        end
    end

endmodule

// File: rtl/edge_det_multi.sv
// Multi-channel edge detector top: WIDTH independent channels with an
// interrupt formed as the OR of all pending flags.
module edge_det_multi
    import edge_det_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   sig,
    input  logic [2*WIDTH-1:0] mode,
    input  logic [WIDTH-1:0]   clr,
    output logic [WIDTH-1:0]   level,
    output logic [WIDTH-1:0]   pe,
    output logic [WIDTH-1:0]   ne,
    output logic [WIDTH-1:0]   ev,
    output logic [WIDTH-1:0]   pend,
    output logic               irq
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .sig   (sig[i]),
            .mode  (mode[2*i +: 2]),
            .clr   (clr[i]),
            .level (level[i]),
            .pe    (pe[i]),
            .ne    (ne[i]),
            .ev    (ev[i]),
            .pend  (pend[i])
        );
    end

    assign irq = |pend;

endmodule
